// File: rtl/jump_issuer.sv
// rtl/jump_issuer.sv - jump request initiator into the program counter
// Accepts decoded instructions, issues one held jump request per taken jump, then flushes fetch.
module jump_issuer #(
  parameter int PC_W      = 2,
  parameter int INSTR_W   = 8,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               status,
  output logic               jump_req,
  output logic [PC_W-1:0]    jump_target,
  input  logic               jump_ack,
  output logic               flush,
  output logic [CNT_W-1:0]   taken_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]       FLUSH_INIT = FLUSH_CYC[3:0];
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               accept;
  logic               taken;
  logic [1:0]         opcode;
  logic               unused_instr;

  assign opcode       = instr[INSTR_W-1:INSTR_W-2];
  assign unused_instr = ^instr[INSTR_W-3:PC_W];
  assign accept       = instr_valid && instr_ready;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      2'b01:   taken = 1'b1;
      2'b10:   taken = !status;
      2'b11:   taken = status;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && taken) state_d = REQ;
      REQ:     if (jump_ack) state_d = (FLUSH_CYC == 0) ? IDLE : FLUSH;
      FLUSH:   if (fcnt_q <= 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Target only loads on an accepted taken jump, so an X on an idle bus never reaches it.
  always_comb begin
    target_d = target_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    if (state_q == IDLE && accept && taken) begin
      target_d = instr[PC_W-1:0];
    end
    if (state_q == REQ && jump_ack) begin
      fcnt_d = FLUSH_INIT;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (state_q == FLUSH && fcnt_q != 4'd0) begin
      fcnt_d = fcnt_q - 4'd1;
    end
  end

  always_comb begin
    instr_ready = (state_q == IDLE) && !rst;
    jump_req    = (state_q == REQ);
    flush       = (state_q == FLUSH);
    jump_target = target_q;
    taken_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_jump_issuer.sv
// tb/tb_jump_issuer.sv - randomized scoreboard bench for jump_issuer
module tb_jump_issuer;

  localparam int FC   = 2;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr = '0;
  logic       status = 1'b0;
  logic       jump_req;
  logic [1:0] jump_target;
  logic       jump_ack = 1'b0;
  logic       flush;
  logic [3:0] taken_cnt;

  jump_issuer #(.PC_W(2), .INSTR_W(8), .FLUSH_CYC(FC), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .status(status), .jump_req(jump_req), .jump_target(jump_target),
    .jump_ack(jump_ack), .flush(flush), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] tgt;
    int         len;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt_m = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops a record at each new request and checks its shape.
  bit prev_req = 1'b0, prev_flush = 1'b0;
  int req_len = 0, flush_len = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (jump_req && !prev_req) begin
        req_len = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 1, 0);
          cur = '{2'b00, 0, 0};
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (jump_req) begin
        req_len++;
        check("req_target", int'(jump_target), int'(cur.tgt));
        check("req_ready_low", int'(instr_ready), 0);
        check("req_no_flush", int'(flush), 0);
      end
      if (!jump_req && prev_req) begin
        check("req_len", req_len, cur.len);
        check("cnt_after_ack", int'(taken_cnt), cur.cnt);
        check("flush_after_ack", int'(flush), (FC > 0) ? 1 : 0);
      end
      if (flush) begin
        flush_len++;
        check("flush_ready_low", int'(instr_ready), 0);
      end
      if (!flush && prev_flush) begin
        check("flush_len", flush_len, FC);
        flush_len = 0;
      end
      prev_req   = jump_req;
      prev_flush = flush;
    end
  end

  function automatic bit model_taken(input logic [7:0] w, input logic st);
    case (w[7:6])
      2'b01:   return 1'b1;
      2'b10:   return st == 1'b0;
      2'b11:   return st == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_txn(input logic [7:0] w, input logic st, input int d);
    bit tk;
    @(negedge clk);
    check("ready_idle", int'(instr_ready), 1);
    check("cnt_idle", int'(taken_cnt), cnt_m);
    check("no_req_idle", int'(jump_req), 0);
    instr_valid = 1'b1;
    instr       = w;
    status      = st;
    jump_ack    = 1'($urandom % 2);
    tk = model_taken(w, st);
    if (tk) begin
      if (cnt_m < CMAX) cnt_m++;
      exp_q.push_back('{w[1:0], d + 1, cnt_m});
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 'x;
    jump_ack    = 1'b0;
    if (tk) begin
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        jump_ack    = (k == d);
        instr_valid = 1'($urandom % 2);
        instr       = 8'($urandom);
      end
      @(posedge clk);
      #1;
      jump_ack = 1'b0; instr_valid = 1'b0; instr = 'x;
      for (int f = 0; f < FC; f++) begin
        @(negedge clk);
        jump_ack    = 1'($urandom % 2);
        instr_valid = 1'($urandom % 2);
        instr       = 8'($urandom);
      end
      @(posedge clk);
      #1;
      jump_ack = 1'b0; instr_valid = 1'b0; instr = 'x;
    end
  endtask

  initial begin
    #2;
    check("rst_ready", int'(instr_ready), 0);
    check("rst_req", int'(jump_req), 0);
    check("rst_flush", int'(flush), 0);
    check("rst_cnt", int'(taken_cnt), 0);
    check("rst_target", int'(jump_target), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", int'(instr_ready), 1);
    mon_en = 1'b1;

    do_txn(8'b01_0000_10, 1'b0, 0);
    do_txn(8'b10_0000_11, 1'b1, 0);
    do_txn(8'b10_0000_11, 1'b0, 0);
    do_txn(8'b11_0000_01, 1'b1, 5);
    do_txn(8'b00_0000_01, 1'b1, 0);
    for (int i = 0; i < 16; i++) do_txn({2'b01, 6'($urandom)}, 1'($urandom % 2), int'($urandom_range(0, 2)));
    for (int i = 0; i < 25; i++) begin
      if ($urandom % 4 == 0) begin
        @(negedge clk);
        jump_ack = 1'b1;
        @(posedge clk);
        #1;
        jump_ack = 1'b0;
      end
      do_txn(8'($urandom), 1'($urandom % 2), int'($urandom_range(0, 5)));
    end
    @(negedge clk);
    @(negedge clk);
    check("cnt_saturated", int'(taken_cnt), CMAX);
    check("queue_drained", exp_q.size(), 0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1; instr = 8'b01_0000_01; status = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    check("pre_rst_req", int'(jump_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", int'(jump_req), 0);
    check("async_rst_flush", int'(flush), 0);
    check("async_rst_cnt", int'(taken_cnt), 0);
    check("async_rst_ready", int'(instr_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_midrst", int'(instr_ready), 1);
    @(posedge clk);
    #1;
    check("no_req_after_midrst", int'(jump_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
